// File: rtl/hub_norm_stage.sv
// Normalization stage of the HUB adder: coarse shift by the anticipated leading-zero count,
// one-position correction, exponent adjust, zero/underflow flush, two-register valid/ready pipe.
module hub_norm_stage #(
   parameter int M           = 24,
   parameter int E           = 8,
   parameter int SHIFT_WIDTH = $clog2(M)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_sign,
   input  logic [E-1:0]           in_exp,
   input  logic [M:0]             in_mant,
   input  logic [SHIFT_WIDTH-1:0] in_shamt,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_sign,
   output logic [E-1:0]           out_exp,
   output logic [M:0]             out_mant,
   output logic                   out_zero,
   output logic                   out_underflow,
   output logic [15:0]            corr_count
);

   localparam int EW  = E + 1;
   localparam int SW1 = SHIFT_WIDTH + 1;
   // One extra bit so the clamp value M is always representable.
   localparam logic [SHIFT_WIDTH:0] MaxSh = SW1'(M);

   // Stage 1 registers
   logic         s1_valid_q;
   logic         s1_sign_q;
   logic         s1_zero_q;
   logic [M:0]   s1_mant_q;
   logic [E:0]   s1_exp_q;

   // Output registers
   logic         out_valid_q;
   logic         out_sign_q;
   logic [E-1:0] out_exp_q;
   logic [M:0]   out_mant_q;
   logic         out_zero_q;
   logic         out_unf_q;
   logic [15:0]  corr_count_q;

   logic               adv;
   logic [SHIFT_WIDTH:0] sh;
   logic [M:0]         s1_mant_d;
   logic [E:0]         s1_exp_d;

   logic               corr;
   logic [M:0]         s2_mant;
   logic [E:0]         s2_exp;
   logic               s2_unf;

   logic               out_sign_d;
   logic [E-1:0]       out_exp_d;
   logic [M:0]         out_mant_d;
   logic               out_zero_d;
   logic               out_unf_d;

   assign adv      = !out_valid_q | out_ready;
   assign in_ready = !s1_valid_q | adv;

   always_comb begin
      sh = ({1'b0, in_shamt} > MaxSh) ? MaxSh : {1'b0, in_shamt};
      s1_mant_d = in_mant << sh;
      s1_exp_d  = {1'b0, in_exp} - EW'(sh);
   end

   // The anticipator is exact or one short, so at most one extra left shift is needed.
   always_comb begin
      corr    = !s1_mant_q[M] & !s1_zero_q;
      s2_mant = corr ? (s1_mant_q << 1) : s1_mant_q;
      s2_exp  = s1_exp_q - EW'(corr);
      s2_unf  = !s1_zero_q & (s2_exp[E] | (s2_exp == '0));
   end

   always_comb begin
      out_sign_d = s1_sign_q;
      out_exp_d  = s2_exp[E-1:0];
      out_mant_d = s2_mant;
      out_zero_d = 1'b0;
      out_unf_d  = 1'b0;
      if (s1_zero_q) begin
         out_sign_d = 1'b0;
         out_exp_d  = '0;
         out_mant_d = '0;
         out_zero_d = 1'b1;
      end else if (s2_unf) begin
         out_exp_d  = '0;
         out_mant_d = '0;
         out_zero_d = 1'b1;
         out_unf_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_sign_q    <= 1'b0;
         s1_zero_q    <= 1'b0;
         s1_mant_q    <= '0;
         s1_exp_q     <= '0;
         out_valid_q  <= 1'b0;
         out_sign_q   <= 1'b0;
         out_exp_q    <= '0;
         out_mant_q   <= '0;
         out_zero_q   <= 1'b0;
         out_unf_q    <= 1'b0;
         corr_count_q <= '0;
      end else begin
         if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_sign_q <= in_sign;
               s1_zero_q <= (in_mant == '0);
               s1_mant_q <= s1_mant_d;
               s1_exp_q  <= s1_exp_d;
            end
         end
         if (adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               out_sign_q <= out_sign_d;
               out_exp_q  <= out_exp_d;
               out_mant_q <= out_mant_d;
               out_zero_q <= out_zero_d;
               out_unf_q  <= out_unf_d;
               if (corr && corr_count_q != 16'hFFFF) begin
                  corr_count_q <= corr_count_q + 16'd1;
               end
            end
         end
      end
   end

   assign out_valid     = out_valid_q;
   assign out_sign      = out_sign_q;
   assign out_exp       = out_exp_q;
   assign out_mant      = out_mant_q;
   assign out_zero      = out_zero_q;
   assign out_underflow = out_unf_q;
   assign corr_count    = corr_count_q;

endmodule

// File: tb/tb_hub_norm_stage.sv
// Bench for hub_norm_stage: directed vectors, backpressure, reset, saturation and random traffic
// checked against a leading-zero-count reference model through an in-order scoreboard.
module tb_hub_norm_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sign = 1'b0;
   logic [7:0]  in_exp = '0;
   logic [24:0] in_mant = '0;
   logic [4:0]  in_shamt = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_sign;
   logic [7:0]  out_exp;
   logic [24:0] out_mant;
   logic        out_zero;
   logic        out_underflow;
   logic [15:0] corr_count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [24:0] mant;
      logic        zero;
      logic        unf;
      logic        corr;
   } beat_t;

   beat_t       q[$];
   logic [15:0] cc = '0;

   hub_norm_stage #(.M(24), .E(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_exp(in_exp),
      .in_mant(in_mant), .in_shamt(in_shamt),
      .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp),
      .out_mant(out_mant), .out_zero(out_zero), .out_underflow(out_underflow),
      .corr_count(corr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: true normalization by leading-zero count; the anticipated shift only decides
   // whether a correction was needed.
   function automatic beat_t model(logic s, logic [7:0] ex, logic [24:0] mt, logic [4:0] sa);
      beat_t  r;
      longint v;
      int     lz, sh, e;
      r = '0;
      if (mt == 0) begin
         r.zero = 1'b1;
         return r;
      end
      v = longint'(mt);
      lz = 0;
      while (v < (64'd1 << 24)) begin
         v = v * 2;
         lz++;
      end
      sh = (int'(sa) > 24) ? 24 : int'(sa);
      r.corr = (sh < lz);
      r.sign = s;
      e = int'(ex) - lz;
      if (e <= 0) begin
         r.zero = 1'b1;
         r.unf  = 1'b1;
      end else begin
         r.exp  = e[7:0];
         r.mant = v[24:0];
      end
      return r;
   endfunction

   task automatic gen(output logic s, output logic [7:0] ex, output logic [24:0] mt,
                      output logic [4:0] sa);
      int p, lz;
      s  = 1'($urandom);
      ex = 8'($urandom);
      if ($urandom % 16 == 0) begin
         mt = '0;
         sa = 5'($urandom);
      end else begin
         p  = $urandom_range(0, 24);
         mt = (25'd1 << p) | (25'($urandom) & ((25'd1 << p) - 25'd1));
         lz = 24 - p;
         if (lz == 24 && $urandom % 2 == 1) sa = 5'($urandom_range(24, 31));
         else if (lz > 0 && $urandom % 2 == 1) sa = 5'(lz - 1);
         else sa = 5'(lz);
      end
   endtask

   // One clock: sample handshakes at the falling edge, then return just after the rising edge.
   task automatic tick(output bit acc, output bit pop);
      beat_t e;
      @(negedge clk);
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (pop) begin
         if (q.size() == 0) begin
            chk("sb_unexpected_beat", 64'(out_valid), 64'd0);
         end else begin
            e = q.pop_front();
            chk("sb_beat", {out_sign, out_exp, out_mant, out_zero, out_underflow},
                {e.sign, e.exp, e.mant, e.zero, e.unf});
         end
      end
      if (acc) begin
         e = model(in_sign, in_exp, in_mant, in_shamt);
         q.push_back(e);
         if (e.corr && cc != 16'hFFFF) cc = cc + 16'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic s, logic [7:0] ex, logic [24:0] mt, logic [4:0] sa);
      in_sign = s; in_exp = ex; in_mant = mt; in_shamt = sa;
   endtask

   task automatic directed(input string tag, input logic s, input logic [7:0] ex,
                           input logic [24:0] mt, input logic [4:0] sa, input logic [24:0] xm,
                           input logic [7:0] xe, input logic xs, input logic xz, input logic xu,
                           input logic [15:0] xcc);
      bit a, p;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(s, ex, mt, sa);
      tick(a, p);
      in_valid = 1'b0;
      tick(a, p);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_mant"}, 64'(out_mant), 64'(xm));
      chk({tag, "_exp"}, 64'(out_exp), 64'(xe));
      chk({tag, "_sign"}, 64'(out_sign), 64'(xs));
      chk({tag, "_flags"}, {out_zero, out_underflow}, {xz, xu});
      chk({tag, "_corr_count"}, 64'(corr_count), 64'(xcc));
      out_ready = 1'b1;
      tick(a, p);
      out_ready = 1'b0;
   endtask

   initial begin
      bit          a, p;
      int          n;
      logic [36:0] held;
      logic        s;
      logic [7:0]  ex;
      logic [24:0] mt;
      logic [4:0]  sa;

      #12;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_corr_count", 64'(corr_count), 64'd0);
      chk("reset_out_mant", 64'(out_mant), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_in_ready", 64'(in_ready), 64'd1);

      directed("exact", 1'b1, 8'd100, 25'h0800000, 5'd1, 25'h1000000, 8'd99, 1'b1, 1'b0, 1'b0,
               16'd0);
      directed("one_short", 1'b0, 8'd100, 25'h0400000, 5'd1, 25'h1000000, 8'd98, 1'b0, 1'b0,
               1'b0, 16'd1);
      directed("cancel", 1'b1, 8'd50, 25'h0, 5'd24, 25'h0, 8'd0, 1'b0, 1'b1, 1'b0, 16'd1);
      directed("underflow", 1'b1, 8'd3, 25'h0100000, 5'd4, 25'h0, 8'd0, 1'b1, 1'b1, 1'b1, 16'd1);
      directed("exp_one", 1'b0, 8'd5, 25'h0100000, 5'd4, 25'h1000000, 8'd1, 1'b0, 1'b0, 1'b0,
               16'd1);
      directed("clamp", 1'b0, 8'd40, 25'h0000001, 5'd31, 25'h1000000, 8'd16, 1'b0, 1'b0, 1'b0,
               16'd1);

      // Backpressure: five beats streamed into a stalled consumer.
      out_ready = 1'b0;
      n = 0;
      gen(s, ex, mt, sa);
      drive(s, ex, mt, sa);
      in_valid = 1'b1;
      while (n < 2) begin
         tick(a, p);
         if (a) begin
            n++;
            gen(s, ex, mt, sa);
            drive(s, ex, mt, sa);
         end
      end
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      held = {out_valid, out_sign, out_exp, out_mant, out_zero, out_underflow};
      tick(a, p);
      tick(a, p);
      tick(a, p);
      chk("bp_held_stable", 64'({out_valid, out_sign, out_exp, out_mant, out_zero,
                                 out_underflow}), 64'(held));
      chk("bp_no_accept_while_full", 64'(a), 64'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(a, p);
         chk("bp_drain_one_per_cycle", 64'(p), 64'd1);
         if (a) begin
            n++;
            if (n < 5) begin
               gen(s, ex, mt, sa);
               drive(s, ex, mt, sa);
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      chk("bp_all_drained", 64'(q.size()), 64'd0);
      chk("bp_beats_sent", 64'(n), 64'd5);

      // Random traffic with random stalls.
      in_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!in_valid || a) begin
            gen(s, ex, mt, sa);
            drive(s, ex, mt, sa);
            in_valid = ($urandom % 4 != 0);
         end
         out_ready = ($urandom % 3 != 0);
         tick(a, p);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() != 0; i++) tick(a, p);
      chk("rand_drained", 64'(q.size()), 64'd0);
      chk("rand_corr_count", 64'(corr_count), 64'(cc));

      // Asynchronous reset with two beats in flight and a stalled consumer.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(1'b0, 8'd100, 25'h0400000, 5'd1);
      tick(a, p);
      tick(a, p);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_corr_count", 64'(corr_count), 64'd0);
      q.delete();
      cc = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_no_stale_valid", 64'(out_valid), 64'd0);

      // Saturation: 65535 correction beats, then one more.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      drive(1'b0, 8'd100, 25'h0400000, 5'd1);
      n = 0;
      while (n < 65535) begin
         tick(a, p);
         if (a) n++;
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick(a, p);
      chk("sat_reach", 64'(corr_count), 64'hFFFF);
      chk("sat_model", 64'(corr_count), 64'(cc));
      in_valid = 1'b1;
      tick(a, p);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick(a, p);
      chk("sat_hold", 64'(corr_count), 64'hFFFF);
      chk("sat_drained", 64'(q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
